div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 XLEN, 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-high (asserted = 1).
REQ-004 DivEn  input  1  decoded M-extension request from IDU, qualified by a valid instruction in EX.
REQ-005 DivSel  input  3  funct3: 100 div, 101 divu, 110 rem, 111 remu; DivSel[2]=0 (multiply) is not this block's request.
REQ-006 Div32  input  1  word variant (divw/divuw/remw/remuw).
REQ-007 src1  input  XLEN  dividend.
REQ-008 src2  input  XLEN  divisor.
REQ-009 flush  input  1  synchronous abort from trap/redirect.
REQ-010 stall_o  output  1  holds the pipeline while a division is pending.
REQ-011 div_valid_o  output  1  result valid for exactly one cycle.
REQ-012 div_result_o  output  XLEN  quotient or remainder.
REQ-013 busy_o  output  1  FSM not in IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, CALC and DONE; it resets to IDLE.
REQ-015 Accept: in IDLE with DivEn=1, DivSel[2]=1 and flush=0, the block SHALL latch the operands, op and Div32, and go to CALC, or to DONE for special cases.
REQ-016 In IDLE, DivEn with DivSel[2]=0 SHALL be ignored: no state change and stall_o=0.
REQ-017 stall_o SHALL equal (IDLE & DivEn & DivSel[2] & ~flush) | CALC, combinationally; it SHALL be 0 in DONE.
REQ-018 Word operands: Div32=1 uses src[31:0], sign-extended for signed ops and zero-extended for unsigned ops.
REQ-019 Signed ops SHALL divide magnitudes and fix signs in DONE: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-020 CALC SHALL perform restoring division, one quotient bit per cycle, for N=64 cycles (N=32 when Div32=1), counted by an iteration counter, then go to DONE.
REQ-021 Latency: accept in cycle T gives div_valid_o=1 in cycle T+N+1 (T+65 or T+33).
REQ-022 Divide by zero: go directly to DONE (valid at T+1); quotient is all ones; remainder is the dividend.
REQ-023 Signed overflow (most-negative dividend, divisor -1, per width): go directly to DONE; quotient is the dividend; remainder is 0.
REQ-024 Div32 results: the 32-bit result SHALL be sign-extended from bit 31 to XLEN for all four W ops.
REQ-025 DONE SHALL last one cycle with div_valid_o=1 and div_result_o valid, then return to IDLE.
REQ-026 A new request SHALL NOT be accepted in DONE; one may be accepted in the IDLE cycle that follows.
REQ-027 div_result_o SHALL be 0 whenever div_valid_o=0.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge with no valid pulse; flush has priority over accept in the same cycle.
REQ-029 busy_o SHALL be 1 in CALC and DONE.

Reset
REQ-030 Asserting rst_n (1), at any time including mid-CALC, SHALL immediately force IDLE, counter=0, stall_o=0, div_valid_o=0, div_result_o=0 and busy_o=0; no pending result survives reset.
REQ-031 After reset release, the first accepted request SHALL behave identically to one accepted after any other IDLE period.

Verification
REQ-032 div: src1=0xFFFFFFFFFFFFFFEC (-20), src2=3, DivSel=100 -> result 0xFFFFFFFFFFFFFFFA; valid at T+65; stall_o high T..T+64.
REQ-033 rem: same operands, DivSel=110 -> result 0xFFFFFFFFFFFFFFFE (-2).
REQ-034 divu by zero: src1=0x1234, src2=0 -> 0xFFFFFFFFFFFFFFFF at T+1; remu with the same operands -> 0x1234 at T+1.
REQ-035 divw overflow: src1=0x80000000, src2=0xFFFFFFFFFFFFFFFF, Div32=1 -> 0xFFFFFFFF80000000; remw with the same operands -> 0.
REQ-036 divuw: src1=0xFFFFFFFE, src2=1 -> 0xFFFFFFFFFFFFFFFE at T+33.
REQ-037 Abort cases:
  - flush in CALC cycle 10 -> IDLE next edge, no valid pulse, stall_o=0.
  - rst_n=1 mid-CALC -> all outputs 0 immediately.
  - back-to-back div issued in the cycle after DONE -> accepted.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle RV64M divide/remainder unit: restoring division on operand magnitudes,
// one quotient bit per cycle, with early exit for divide-by-zero and signed overflow.
module div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            DivEn,
    input  logic [2:0]      DivSel,
    input  logic            Div32,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall_o,
    output logic            div_valid_o,
    output logic [XLEN-1:0] div_result_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [6:0]        cnt_r;
    logic [XLEN-1:0]   a_r, b_r, q_r, r_r;
    logic              w_r, rem_r, neg_q_r, neg_r_r;

    logic              sgn_s, neg1_s, neg2_s, dz_s, ovf_s, accept_s, qbit_s;
    logic [XLEN-1:0]   op1_s, op2_s, mag1_s, mag2_s, min_s;
    logic [XLEN:0]     trial_s;
    logic [XLEN-1:0]   q_mag_s, q_fix_s, r_fix_s, res_s;
    logic [6:0]        last_s;

    // Operand extension, magnitudes and special-case detection at accept time
    always_comb begin
        sgn_s = ~DivSel[0];
        if (Div32) begin
            op1_s = sgn_s ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
            op2_s = sgn_s ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
            min_s = {{(XLEN-31){1'b1}}, 31'd0};
        end else begin
            op1_s = src1;
            op2_s = src2;
            min_s = {1'b1, {(XLEN-1){1'b0}}};
        end
        neg1_s   = sgn_s & op1_s[XLEN-1];
        neg2_s   = sgn_s & op2_s[XLEN-1];
        mag1_s   = neg1_s ? ({XLEN{1'b0}} - op1_s) : op1_s;
        mag2_s   = neg2_s ? ({XLEN{1'b0}} - op2_s) : op2_s;
        dz_s     = (op2_s == {XLEN{1'b0}});
        ovf_s    = sgn_s & (op1_s == min_s) & (op2_s == {XLEN{1'b1}});
        accept_s = (state_r == IDLE) & DivEn & DivSel[2] & ~flush;
    end

    // One restoring step: shift next dividend bit into the partial remainder and try to subtract
    always_comb begin
        trial_s = {r_r, a_r[XLEN-1]} - {1'b0, b_r};
        qbit_s  = ~trial_s[XLEN];
        last_s  = w_r ? 7'd31 : 7'd63;
    end

    // Sign fix-up and word sign-extension of the final result
    always_comb begin
        q_mag_s = w_r ? {{(XLEN-32){1'b0}}, q_r[31:0]} : q_r;
        q_fix_s = neg_q_r ? ({XLEN{1'b0}} - q_mag_s) : q_mag_s;
        r_fix_s = neg_r_r ? ({XLEN{1'b0}} - r_r) : r_r;
        res_s   = rem_r ? r_fix_s : q_fix_s;
        if (w_r) begin
            res_s = {{(XLEN-32){res_s[31]}}, res_s[31:0]};
        end else begin
            res_s = res_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = (dz_s | ovf_s) ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (cnt_r == last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath: operand latch on accept, iterate in CALC
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_r   <= 7'd0;
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
            q_r     <= {XLEN{1'b0}};
            r_r     <= {XLEN{1'b0}};
            w_r     <= 1'b0;
            rem_r   <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (flush) begin
            cnt_r <= 7'd0;
        end else if (accept_s) begin
            cnt_r   <= 7'd0;
            w_r     <= Div32;
            rem_r   <= DivSel[1];
            neg_q_r <= (neg1_s ^ neg2_s) & ~dz_s & ~ovf_s;
            neg_r_r <= neg1_s & ~dz_s & ~ovf_s;
            b_r     <= mag2_s;
            if (dz_s) begin
                a_r <= {XLEN{1'b0}};
                q_r <= {XLEN{1'b1}};
                r_r <= op1_s;
            end else if (ovf_s) begin
                a_r <= {XLEN{1'b0}};
                q_r <= op1_s;
                r_r <= {XLEN{1'b0}};
            end else begin
                a_r <= Div32 ? {mag1_s[31:0], {(XLEN-32){1'b0}}} : mag1_s;
                q_r <= {XLEN{1'b0}};
                r_r <= {XLEN{1'b0}};
            end
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + 7'd1;
            a_r   <= {a_r[XLEN-2:0], 1'b0};
            q_r   <= {q_r[XLEN-2:0], qbit_s};
            r_r   <= qbit_s ? trial_s[XLEN-1:0] : {r_r[XLEN-2:0], a_r[XLEN-1]};
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        stall_o      = accept_s | (state_r == CALC);
        busy_o       = (state_r != IDLE);
        div_valid_o  = (state_r == DONE);
        div_result_o = (state_r == DONE) ? res_s : {XLEN{1'b0}};
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed, table-driven bench for div_ctrl with hand-written abort/back-to-back sequences.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        DivEn;
    logic [2:0]  DivSel;
    logic        Div32;
    logic [63:0] src1, src2;
    logic        flush;
    logic        stall_o, div_valid_o, busy_o;
    logic [63:0] div_result_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    div_ctrl #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .DivEn(DivEn), .DivSel(DivSel), .Div32(Div32),
        .src1(src1), .src2(src2), .flush(flush), .stall_o(stall_o),
        .div_valid_o(div_valid_o), .div_result_o(div_result_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        DivEn = 1'b1; DivSel = v.sel; Div32 = v.w; src1 = v.a; src2 = v.b;
        #1;
        chk({v.name, " stall@T"}, 64'(stall_o), 64'd1);
        @(negedge clk);
        DivEn = 1'b0;
        lat = 1;
        while (!div_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " result"}, div_result_o, v.exp);
        chk({v.name, " stall@DONE"}, 64'(stall_o), 64'd0);
        chk({v.name, " busy@DONE"}, 64'(busy_o), 64'd1);
        @(negedge clk);
        chk({v.name, " idle after"}, {61'd0, div_valid_o, busy_o, |div_result_o}, 64'd0);
    endtask

    initial begin
        int vcount;
        vecs[0]  = '{"div -20/3",      3'b100, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFA, 65};
        vecs[1]  = '{"rem -20/3",      3'b110, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFE, 65};
        vecs[2]  = '{"divu by 0",      3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1};
        vecs[3]  = '{"remu by 0",      3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 1};
        vecs[4]  = '{"divw ovf",       3'b100, 1'b1, 64'h80000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 1};
        vecs[5]  = '{"remw ovf",       3'b110, 1'b1, 64'h80000000, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1};
        vecs[6]  = '{"divuw big",      3'b101, 1'b1, 64'hFFFFFFFE, 64'd1, 64'hFFFFFFFFFFFFFFFE, 33};
        vecs[7]  = '{"divu 100/7",     3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[8]  = '{"remu 100/7",     3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65};
        vecs[9]  = '{"div ovf64",      3'b100, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1};
        vecs[10] = '{"remw -7/2",      3'b110, 1'b1, 64'h12345678FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33};
        vecs[11] = '{"divw -7/2",      3'b100, 1'b1, 64'h12345678FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 33};
        vecs[12] = '{"div 7/-2",       3'b100, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 65};
        vecs[13] = '{"rem 7/-2",       3'b110, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'd1, 65};
        vecs[14] = '{"remuw",          3'b111, 1'b1, 64'h80000005, 64'h10, 64'd5, 33};
        vecs[15] = '{"divuw",          3'b101, 1'b1, 64'h80000005, 64'h10, 64'h08000000, 33};
        vecs[16] = '{"divw by 0",      3'b100, 1'b1, 64'd5, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF, 1};
        vcount = 17;

        rst_n = 1'b1; DivEn = 1'b0; DivSel = 3'b000; Div32 = 1'b0;
        src1 = 64'd0; src2 = 64'd0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {60'd0, stall_o, div_valid_o, busy_o, |div_result_o}, 64'd0);
        rst_n = 1'b0;

        for (int i = 0; i < vcount; i++) run_vec(vecs[i]);

        // multiply request is ignored
        @(negedge clk);
        DivEn = 1'b1; DivSel = 3'b000; src1 = 64'd9; src2 = 64'd3; #1;
        chk("mul ignored stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("mul ignored busy", 64'(busy_o), 64'd0);
        DivEn = 1'b0;

        // flush beats accept in IDLE
        @(negedge clk);
        DivEn = 1'b1; DivSel = 3'b100; Div32 = 1'b0; src1 = 64'd20; src2 = 64'd3; flush = 1'b1; #1;
        chk("flush@accept stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        DivEn = 1'b0; flush = 1'b0;
        chk("flush@accept busy", 64'(busy_o), 64'd0);

        // flush in CALC cycle 10
        @(negedge clk);
        DivEn = 1'b1; DivSel = 3'b100; src1 = 64'hFFFFFFFFFFFFFFEC; src2 = 64'd3;
        @(negedge clk);
        DivEn = 1'b0;
        repeat (9) @(negedge clk);
        chk("calc10 busy", 64'(busy_o), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush calc state", {61'd0, stall_o, busy_o, div_valid_o}, 64'd0);
        begin
            int pulses = 0;
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                if (div_valid_o) pulses++;
            end
            chk("flush no valid", 64'(pulses), 64'd0);
        end

        // reset mid-CALC
        @(negedge clk);
        DivEn = 1'b1; DivSel = 3'b101; src1 = 64'd1000; src2 = 64'd7;
        @(negedge clk);
        DivEn = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1; #1;
        chk("reset midcalc", {60'd0, stall_o, div_valid_o, busy_o, |div_result_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        begin
            int pulses = 0;
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                if (div_valid_o) pulses++;
            end
            chk("reset no survivor", 64'(pulses), 64'd0);
        end
        run_vec(vecs[7]);

        // back-to-back: request held through DONE is accepted only in the following IDLE
        @(negedge clk);
        DivEn = 1'b1; DivSel = 3'b101; Div32 = 1'b0; src1 = 64'h1234; src2 = 64'd0;
        @(negedge clk);
        DivSel = 3'b111; #1;
        chk("b2b done valid", 64'(div_valid_o), 64'd1);
        chk("b2b done result", div_result_o, 64'hFFFFFFFFFFFFFFFF);
        chk("b2b no accept in DONE", 64'(stall_o), 64'd0);
        @(negedge clk); #1;
        chk("b2b accept idle", 64'(stall_o), 64'd1);
        chk("b2b idle valid", 64'(div_valid_o), 64'd0);
        @(negedge clk);
        DivEn = 1'b0;
        chk("b2b second valid", 64'(div_valid_o), 64'd1);
        chk("b2b second result", div_result_o, 64'h1234);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
